// File: rtl/hfrv_mem_arbiter.sv
// Two-master round-robin arbiter sharing one synchronous SRAM port between the
// core (M0) and the debug/loader port (M1), with bounded M1 lock and read routing.
module hfrv_mem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic [DATA_W/8-1:0]   m0_we,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic                  m0_stall,
  input  logic                  m1_req,
  input  logic [DATA_W/8-1:0]   m1_we,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic                  m1_lock,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic                  mem_en,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned HOLD_W = 8;

  logic              r_last;      // last granted master, 1 = M1
  logic              r_prev_gnt;  // any grant on the previous cycle
  logic              r_lock_prev;
  logic [HOLD_W-1:0] r_hold;
  logic              r_rd_pend;
  logic              r_rd_owner;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;

  logic w_both;
  logic w_sel1;
  logic w_g0;
  logic w_g1;
  logic w_rd;

  // Grant decision: round-robin on contention, lock honoured until hold limit
  always_comb begin
    w_both = m0_req & m1_req;
    w_sel1 = m1_req;
    if (w_both) begin
      if (r_hold == HOLD_W'(MAX_HOLD)) begin
        w_sel1 = ~r_last;
      end else if (r_lock_prev) begin
        w_sel1 = 1'b1;
      end else begin
        w_sel1 = ~r_last;
      end
    end
    w_g1 = m1_req & w_sel1;
    w_g0 = m0_req & ~w_sel1;
  end

  assign m0_gnt    = w_g0;
  assign m1_gnt    = w_g1;
  assign m0_stall  = m0_req & ~w_g0;
  assign mem_en    = w_g0 | w_g1;
  assign mem_we    = w_g1 ? m1_we : (w_g0 ? m0_we : '0);
  assign mem_addr  = w_g1 ? m1_addr : m0_addr;
  assign mem_wdata = w_g1 ? m1_wdata : m0_wdata;
  assign w_rd      = mem_en & (mem_we == '0);

  // SRAM data arrives the cycle after the grant; non-owner keeps its last word
  assign m0_rvalid = r_rd_pend & ~r_rd_owner;
  assign m1_rvalid = r_rd_pend & r_rd_owner;
  assign m0_rdata  = m0_rvalid ? mem_rdata : r_m0_rdata;
  assign m1_rdata  = m1_rvalid ? mem_rdata : r_m1_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last      <= 1'b1;
      r_prev_gnt  <= 1'b0;
      r_lock_prev <= 1'b0;
      r_hold      <= '0;
      r_rd_pend   <= 1'b0;
      r_rd_owner  <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_prev_gnt  <= mem_en;
      r_lock_prev <= w_g1 & m1_lock;
      r_rd_pend   <= w_rd;
      if (w_rd) begin
        r_rd_owner <= w_g1;
      end
      if (mem_en) begin
        r_last <= w_g1;
      end
      // Hold counts consecutive contested grants to the same master
      if (!mem_en) begin
        r_hold <= '0;
      end else if (r_prev_gnt && (w_g1 != r_last)) begin
        r_hold <= HOLD_W'(1);
      end else if (w_both && (r_hold != HOLD_W'(MAX_HOLD))) begin
        r_hold <= r_hold + HOLD_W'(1);
      end
      if (m0_rvalid) begin
        r_m0_rdata <= mem_rdata;
      end
      if (m1_rvalid) begin
        r_m1_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_hfrv_mem_arbiter.sv
// Bench for hfrv_mem_arbiter: directed scenarios plus random traffic, all checked
// against a transaction-level arbitration/memory model kept in the bench.
module tb_hfrv_mem_arbiter;

  localparam int unsigned AW       = 32;
  localparam int unsigned DW       = 32;
  localparam int unsigned BW       = DW / 8;
  localparam int unsigned MAX_HOLD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req = 1'b0, m1_req = 1'b0, m1_lock = 1'b0;
  logic [BW-1:0] m0_we = '0, m1_we = '0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_stall, mem_en;
  logic [DW-1:0] m0_rdata, m1_rdata, mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [BW-1:0] mem_we;
  logic [AW-1:0] mem_addr;

  hfrv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_stall(m0_stall),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(logic [31:0] o, logic [3:0] be, logic [31:0] d);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Synchronous SRAM: one-cycle read latency, byte-enabled writes
  logic [31:0] sram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'h0) mem_rdata <= sram[mem_addr[9:2]];
      else sram[mem_addr[9:2]] <= merge(sram[mem_addr[9:2]], mem_we, mem_wdata);
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pending master transactions (held until granted)
  logic        rq [2];
  logic [3:0]  we [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic        lk;

  // Reference model state
  logic [31:0] ref_mem [256];
  int          m_last, m_hold, m_prev_g, m_own;
  logic        m_lockprev, m_rv;
  logic [31:0] m_rv_data;
  logic [31:0] m_rdata [2];

  task automatic mreset();
    m_last = 1; m_hold = 0; m_prev_g = -1; m_own = 0;
    m_lockprev = 1'b0; m_rv = 1'b0; m_rv_data = '0;
    m_rdata[0] = '0; m_rdata[1] = '0;
    rq[0] = 1'b0; rq[1] = 1'b0; lk = 1'b0;
  endtask

  task automatic arm(input int id, input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    rq[id] = 1'b1; we[id] = be; ad[id] = a; wd[id] = d;
  endtask

  // One clock: drive pending requests, compare DUT against model, advance model
  task automatic step(output int dg);
    int          g;
    int          oth;
    logic [7:0]  ix;
    logic [31:0] e0, e1;
    @(negedge clk);
    m0_req = rq[0]; m0_we = we[0]; m0_addr = ad[0]; m0_wdata = wd[0];
    m1_req = rq[1]; m1_we = we[1]; m1_addr = ad[1]; m1_wdata = wd[1];
    m1_lock = lk;
    #1;
    dg = m1_gnt ? 1 : (m0_gnt ? 0 : -1);
    if (!rq[0] && !rq[1])        g = -1;
    else if (!rq[1])             g = 0;
    else if (!rq[0])             g = 1;
    else if (m_hold >= MAX_HOLD) g = 1 - m_last;
    else if (m_lockprev)         g = 1;
    else                         g = 1 - m_last;
    check_val("m0_gnt", 32'(m0_gnt), 32'(g == 0));
    check_val("m1_gnt", 32'(m1_gnt), 32'(g == 1));
    check_val("m0_stall", 32'(m0_stall), 32'(rq[0] && g != 0));
    check_val("mem_en", 32'(mem_en), 32'(g >= 0));
    if (g >= 0) begin
      check_val("mem_we", 32'(mem_we), 32'(we[g]));
      check_val("mem_addr", mem_addr, ad[g]);
      if (we[g] != 4'h0) check_val("mem_wdata", mem_wdata, wd[g]);
    end else begin
      check_val("mem_we_idle", 32'(mem_we), 32'(0));
    end
    check_val("m0_rvalid", 32'(m0_rvalid), 32'(m_rv && m_own == 0));
    check_val("m1_rvalid", 32'(m1_rvalid), 32'(m_rv && m_own == 1));
    e0 = (m_rv && m_own == 0) ? m_rv_data : m_rdata[0];
    e1 = (m_rv && m_own == 1) ? m_rv_data : m_rdata[1];
    check_val("m0_rdata", m0_rdata, e0);
    check_val("m1_rdata", m1_rdata, e1);
    m_rdata[0] = e0; m_rdata[1] = e1;
    m_rv = 1'b0;
    if (g >= 0) begin
      ix = ad[g][9:2];
      if (we[g] == 4'h0) begin
        m_rv = 1'b1; m_own = g; m_rv_data = ref_mem[ix];
      end else begin
        ref_mem[ix] = merge(ref_mem[ix], we[g], wd[g]);
      end
      oth = 1 - g;
      if (m_prev_g >= 0 && m_prev_g != g)       m_hold = 1;
      else if (rq[oth] && m_hold < MAX_HOLD)    m_hold = m_hold + 1;
      m_last = g;
      m_lockprev = (g == 1) && lk;
      rq[g] = 1'b0;
    end else begin
      m_hold = 0;
      m_lockprev = 1'b0;
    end
    m_prev_g = g;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    #1;
    check_val("rst_m0_rvalid", 32'(m0_rvalid), 32'(0));
    check_val("rst_m1_rvalid", 32'(m1_rvalid), 32'(0));
    check_val("rst_m0_rdata", m0_rdata, 32'(0));
    check_val("rst_m1_rdata", m1_rdata, 32'(0));
    check_val("rst_mem_en", 32'(mem_en), 32'(0));
    check_val("rst_mem_we", 32'(mem_we), 32'(0));
    mreset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  int dg, prev, cnt;
  int lock_exp [5];

  initial begin
    lock_exp = '{1, 1, 1, 1, 0};
    we[0] = '0; we[1] = '0; ad[0] = '0; ad[1] = '0; wd[0] = '0; wd[1] = '0;
    mreset();
    do_reset();

    // Preload the working set through the loader port
    for (int i = 0; i < 8; i++) begin
      arm(1, 4'hF, 32'h100 + 32'(i) * 4, $urandom);
      step(dg);
    end
    arm(1, 4'hF, 32'h100, 32'hDEADBEEF); step(dg);
    arm(1, 4'hF, 32'h200, 32'h11223344); step(dg);
    step(dg);

    // Single M0 read
    arm(0, 4'h0, 32'h100, 32'h0);
    step(dg);
    check_val("t1_gnt", 32'(dg), 32'(0));
    step(dg);
    check_val("t1_rdata", m0_rdata, 32'hDEADBEEF);
    check_val("t1_m1_rvalid", 32'(m1_rvalid), 32'(0));

    // Continuous contention without lock alternates
    prev = -1;
    for (int k = 0; k < 8; k++) begin
      if (!rq[0]) arm(0, 4'h0, 32'h100 + 32'($urandom_range(0, 7)) * 4, 32'h0);
      if (!rq[1]) arm(1, 4'h0, 32'h100 + 32'($urandom_range(0, 7)) * 4, 32'h0);
      step(dg);
      if (k > 0) check_val("rr_alt", 32'(dg), 32'(1 - prev));
      prev = dg;
    end
    rq[0] = 1'b0; rq[1] = 1'b0;
    step(dg);

    // Locked M1 writes against a waiting M0 are cut off at MAX_HOLD
    arm(0, 4'h0, 32'h104, 32'h0); step(dg);
    lk = 1'b1;
    arm(0, 4'h0, 32'h108, 32'h0);
    for (int k = 0; k < 5; k++) begin
      if (!rq[1]) arm(1, 4'hF, 32'h100 + 32'($urandom_range(0, 7)) * 4, $urandom);
      step(dg);
      check_val("lock_seq", 32'(dg), 32'(lock_exp[k]));
    end
    rq[0] = 1'b0; rq[1] = 1'b0; lk = 1'b0;
    step(dg);

    // Uncontested lock never forces a switch or builds up hold
    lk = 1'b1; cnt = 0;
    for (int k = 0; k < 20; k++) begin
      arm(1, 4'hF, 32'h100 + 32'($urandom_range(0, 7)) * 4, $urandom);
      step(dg);
      if (dg == 1) cnt++;
    end
    check_val("lock_idle_cnt", 32'(cnt), 32'(20));
    arm(0, 4'h0, 32'h10C, 32'h0);
    for (int k = 0; k < 5; k++) begin
      if (!rq[1]) arm(1, 4'hF, 32'h100 + 32'($urandom_range(0, 7)) * 4, $urandom);
      step(dg);
      check_val("lock_after_idle", 32'(dg), 32'(lock_exp[k]));
    end
    rq[0] = 1'b0; rq[1] = 1'b0; lk = 1'b0;
    step(dg);

    // Byte write then read-back
    arm(0, 4'h1, 32'h200, 32'h000000AA); step(dg);
    check_val("t5_wr_gnt", 32'(dg), 32'(0));
    arm(0, 4'h0, 32'h200, 32'h0); step(dg);
    check_val("t5_wr_no_rvalid", 32'(m0_rvalid), 32'(0));
    step(dg);
    check_val("t5_rvalid", 32'(m0_rvalid), 32'(1));
    check_val("t5_rdata", m0_rdata, 32'h112233AA);

    // Reset while an M1 read is in flight
    arm(1, 4'h0, 32'h104, 32'h0); step(dg);
    do_reset();
    arm(0, 4'h0, 32'h108, 32'h0);
    arm(1, 4'h0, 32'h10C, 32'h0);
    step(dg);
    check_val("post_rst_first", 32'(dg), 32'(0));
    rq[0] = 1'b0; rq[1] = 1'b0;
    step(dg); step(dg);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rq[i] && $urandom_range(0, 99) < 60)
          arm(i, ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0,
              32'h100 + 32'($urandom_range(0, 7)) * 4, $urandom);
        else if (rq[i] && $urandom_range(0, 99) < 3)
          rq[i] = 1'b0;
      end
      lk = ($urandom_range(0, 99) < 50);
      step(dg);
    end
    rq[0] = 1'b0; rq[1] = 1'b0;
    step(dg); step(dg);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hfrv_mem_arbiter.md
Name: hfrv_mem_arbiter

Overview:
- Two-master, single-port memory arbiter for the hf-riscv memory subsystem. Shares one synchronous SRAM port between the core's memory port (M0) and the debug/code-loader port (M1) that fills memory and peeks at it during simulation.
- Arbitration is round-robin. M1 may lock the port for short bursts, with a bounded hold.
- Produces the core stall indication and routes read data back to the granted master after the fixed SRAM latency.

Parameters:
- ADDR_W, 32, address width of masters and memory port
- DATA_W, 32, data width; byte enables are DATA_W/8
- MAX_HOLD, 8, maximum consecutive grants to one master while the other is requesting (range 1..255)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- m0_req  in  1  core request
- m0_we  in  DATA_W/8  core byte write enables; 0 = read
- m0_addr  in  ADDR_W  core address
- m0_wdata  in  DATA_W  core write data
- m0_gnt  out  1  core request accepted this cycle
- m0_rvalid  out  1  core read data valid
- m0_rdata  out  DATA_W  core read data
- m0_stall  out  1  core must hold state (m0_req & ~m0_gnt)
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as M0, for the loader
- m1_lock  in  1  M1 requests to keep ownership on following cycles
- mem_en  out  1  SRAM access enable
- mem_we  out  DATA_W/8  SRAM byte write enables
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid 1 cycle after mem_en with mem_we == 0

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - rvalid outputs, mem_en and mem_we are 0.
  - last-grant pointer = M1, so M0 wins the first tie.
  - hold counter = 0; rd_pend = 0; rd_owner = 0; rdata outputs are 0.
- Grant decision (combinational, same cycle as request):
  - Exactly one of m0_gnt/m1_gnt can be 1.
  - Only one requesting: that master is granted.
  - Both requesting: the master not granted last cycle wins (round-robin).
  - Exception 1: if M1 was granted last cycle with m1_lock = 1 and hold < MAX_HOLD, M1 wins.
  - Exception 2: if hold == MAX_HOLD, the other master wins regardless of lock.
- Memory drive:
  - mem_en = m0_gnt | m1_gnt.
  - mem_we, mem_addr and mem_wdata are muxed from the granted master.
  - When neither is granted: mem_en = 0, mem_we = 0, and addr/wdata are don't-care (drive M0 values).
- Hold counter:
  - Increments when the same master is granted on consecutive cycles while the other is requesting, saturating at MAX_HOLD.
  - Resets to 1 when the granted master changes.
  - Resets to 0 on an idle cycle.
  - Uncontested consecutive grants do not increment it.
- Read return:
  - A granted read (we == 0) sets rd_pend = 1 and rd_owner = granted id at the next edge.
  - Next cycle: rvalid of rd_owner = 1 and its rdata = mem_rdata; the other master's rvalid = 0 and its rdata holds its previous value.
  - Latency is request-grant cycle + 1. Back-to-back reads give one rvalid per cycle in grant order.
  - Writes produce no rvalid and complete at the grant edge.
- Masters hold req/addr/we/wdata stable until gnt. Dropping req without gnt is legal; no access occurs.
- m1_lock is ignored when m1_req = 0; lock with no M0 request has no effect on the counter.
- Reset mid-read: a pending rvalid is discarded (rvalid = 0 after reset). Reset mid-lock clears ownership and hold.
- m0_stall is purely combinational: m0_req & ~m0_gnt.

Test Plan:
- Reset, then M0 read only at 0x100 with SRAM returning 0xDEADBEEF -> m0_gnt same cycle, mem_en = 1, mem_addr = 0x100; next cycle m0_rvalid = 1, m0_rdata = 0xDEADBEEF; m1_rvalid = 0.
- M0 and M1 both request continuously, no lock -> grants alternate M0, M1, M0, M1…; m0_stall = 1 on M1 cycles; each rvalid is tagged to the correct owner.
- MAX_HOLD = 4, M1 writes with m1_lock = 1, M0 requesting -> M1 granted 4 consecutive cycles, then M0 granted on the 5th; mem_we equals the M1 byte enables (e.g. 0xF) on those cycles.
- M1 lock with M0 idle for 20 cycles -> M1 granted every cycle, no forced switch; hold counter stays 0.
- M0 byte write we = 0x1, addr 0x200, data 0x000000AA, then a read of 0x200 -> mem_we = 0x1 on the write cycle, no rvalid for it; the read returns the value via m0_rvalid one cycle after its grant.
- Assert reset the cycle after a granted M1 read -> m1_rvalid stays 0; after release the first contested request goes to M0.
